// File: rtl/next_pc_unit.sv
// Branch/jump resolution stage: updates the architectural PC, issues fetch
// redirects on taken transfers and traps on illegal or misaligned targets.
module next_pc_unit #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 'h8000_0000,
    parameter int unsigned IALIGN = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] alu_C_i,
    input  logic                  br_i,
    input  logic                  jal_i,
    input  logic                  jalr_i,
    input  logic [2:0]            brty_i,
    input  logic [DATA_WIDTH-1:0] imme_i,
    input  logic [DATA_WIDTH-1:0] rs1_i,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    input  logic                  redirect_ready_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  link_valid_o,
    output logic [DATA_WIDTH-1:0] link_o,
    output logic                  exc_valid_o,
    output logic [1:0]            exc_cause_o,
    output logic [DATA_WIDTH-1:0] exc_tval_o,
    input  logic                  trap_clear_i,
    input  logic [DATA_WIDTH-1:0] trap_vec_i,
    output logic [CNT_W-1:0]      retire_cnt_o,
    output logic [CNT_W-1:0]      taken_cnt_o
);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        TRAP
    } state_t;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

    localparam logic [DATA_WIDTH-1:0] INSN_BYTES = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] ONE        = DATA_WIDTH'(1);

    state_t                  state_q, state_n;
    logic [DATA_WIDTH-1:0]   pc_q, pc_n;
    logic                    rv_q, rv_n;
    logic [DATA_WIDTH-1:0]   rpc_q, rpc_n;
    logic                    lv_q, lv_n;
    logic [DATA_WIDTH-1:0]   link_q, link_n;
    logic                    ev_q, ev_n;
    logic [1:0]              cause_q, cause_n;
    logic [DATA_WIDTH-1:0]   tval_q, tval_n;
    logic [CNT_W-1:0]        retire_q, retire_n;
    logic [CNT_W-1:0]        taken_q, taken_n;

    logic                    accept;
    logic                    alu_zero;
    logic                    alu_one;
    logic                    br_cond;
    logic                    brty_bad;
    logic                    taken;
    logic                    is_link;
    logic                    illegal;
    logic                    misaligned;
    logic                    tgt_bad;
    logic [DATA_WIDTH-1:0]   seq_pc;
    logic [DATA_WIDTH-1:0]   rel_tgt;
    logic [DATA_WIDTH-1:0]   ind_sum;
    logic [DATA_WIDTH-1:0]   ind_tgt;
    logic [DATA_WIDTH-1:0]   target;

    assign in_ready_o = (state_q == RUN);
    assign accept     = in_valid_i & in_ready_o;

    assign alu_zero = (alu_C_i == '0);
    assign alu_one  = (alu_C_i == ONE);

    assign seq_pc  = pc_i + INSN_BYTES;
    assign rel_tgt = pc_i + imme_i;
    assign ind_sum = rs1_i + imme_i;
    assign ind_tgt = {ind_sum[DATA_WIDTH-1:1], 1'b0};

    always_comb begin
        br_cond  = 1'b0;
        brty_bad = 1'b0;
        unique case (brty_i)
            BR_EQ:  br_cond = alu_zero;
            BR_NE:  br_cond = ~alu_zero;
            BR_LT:  br_cond = alu_one;
            BR_GE:  br_cond = alu_zero;
            BR_LTU: br_cond = alu_one;
            BR_GEU: br_cond = alu_zero;
            default: brty_bad = 1'b1;
        endcase
    end

    // Flags may overlap; br outranks jal, which outranks jalr.
    always_comb begin
        target = seq_pc;
        taken  = 1'b0;
        priority case (1'b1)
            br_i: begin
                taken  = br_cond & ~brty_bad;
                target = taken ? rel_tgt : seq_pc;
            end
            jal_i: begin
                taken  = 1'b1;
                target = rel_tgt;
            end
            jalr_i: begin
                taken  = 1'b1;
                target = ind_tgt;
            end
            default: begin
                taken  = 1'b0;
                target = seq_pc;
            end
        endcase
    end

    assign is_link = ~br_i & (jal_i | jalr_i);
    assign illegal = br_i & brty_bad;

    generate
        if (IALIGN == 16) begin : g_align16
            assign tgt_bad = target[0];
        end else begin : g_align32
            assign tgt_bad = |target[1:0];
        end
    endgenerate

    assign misaligned = taken & tgt_bad;

    always_comb begin
        state_n  = state_q;
        pc_n     = pc_q;
        rv_n     = rv_q;
        rpc_n    = rpc_q;
        lv_n     = 1'b0;
        link_n   = link_q;
        ev_n     = ev_q;
        cause_n  = cause_q;
        tval_n   = tval_q;
        retire_n = retire_q;
        taken_n  = taken_q;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    if (illegal | misaligned) begin
                        state_n = TRAP;
                        ev_n    = 1'b1;
                        cause_n = illegal ? CAUSE_ILLEGAL
                                          : CAUSE_MISALIGN;
                        tval_n  = illegal ? pc_i : target;
                    end else begin
                        pc_n     = target;
                        retire_n = retire_q + CNT_W'(1);
                        if (is_link) begin
                            lv_n   = 1'b1;
                            link_n = seq_pc;
                        end
                        if (taken) begin
                            state_n = HOLD;
                            taken_n = taken_q + CNT_W'(1);
                            rv_n    = 1'b1;
                            rpc_n   = target;
                        end
                    end
                end
            end
            HOLD: begin
                if (rv_q & redirect_ready_i) begin
                    rv_n    = 1'b0;
                    state_n = RUN;
                end
            end
            TRAP: begin
                // The handler vector is trusted and loaded as-is.
                if (trap_clear_i) begin
                    ev_n    = 1'b0;
                    pc_n    = trap_vec_i;
                    rv_n    = 1'b1;
                    rpc_n   = trap_vec_i;
                    state_n = HOLD;
                end
            end
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            lv_q     <= 1'b0;
            link_q   <= '0;
            ev_q     <= 1'b0;
            cause_q  <= '0;
            tval_q   <= '0;
            retire_q <= '0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_n;
            pc_q     <= pc_n;
            rv_q     <= rv_n;
            rpc_q    <= rpc_n;
            lv_q     <= lv_n;
            link_q   <= link_n;
            ev_q     <= ev_n;
            cause_q  <= cause_n;
            tval_q   <= tval_n;
            retire_q <= retire_n;
            taken_q  <= taken_n;
        end
    end

    assign pc_o             = pc_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rpc_q;
    assign link_valid_o     = lv_q;
    assign link_o           = link_q;
    assign exc_valid_o      = ev_q;
    assign exc_cause_o      = cause_q;
    assign exc_tval_o       = tval_q;
    assign retire_cnt_o     = retire_q;
    assign taken_cnt_o      = taken_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: expected output snapshots are queued
// as stimulus is driven and compared one cycle later.
module tb_next_pc_unit;

    typedef struct packed {
        logic        rdy;
        logic        rv;
        logic [63:0] rpc;
        logic [63:0] pc;
        logic        lv;
        logic [63:0] lnk;
        logic        ev;
        logic [1:0]  cause;
        logic [63:0] tval;
        logic [31:0] rcnt;
        logic [31:0] tcnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rst16_n;
    logic        in_valid;
    logic [63:0] pc_in;
    logic [63:0] alu_c;
    logic        br, jal, jalr;
    logic [2:0]  brty;
    logic [63:0] imme, rs1;
    logic        redirect_ready;
    logic        trap_clear;
    logic [63:0] trap_vec;

    logic        in_ready, rv, lv, ev;
    logic [63:0] rpc, pc_out, lnk, tval;
    logic [1:0]  cause;
    logic [31:0] rcnt, tcnt;

    logic        in_ready16, rv16, lv16, ev16;
    logic [63:0] rpc16, pc16, lnk16, tval16;
    logic [1:0]  cause16;
    logic [31:0] rcnt16, tcnt16;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];
    obs_t e, e16, got, want;

    localparam obs_t RST_OBS = '{rdy: 1'b1, rv: 1'b0, rpc: 64'h0,
        pc: 64'h8000_0000, lv: 1'b0, lnk: 64'h0, ev: 1'b0,
        cause: 2'd0, tval: 64'h0, rcnt: 32'd0, tcnt: 32'd0};

    always #5 clk = ~clk;

    next_pc_unit #(.IALIGN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pc_i(pc_in), .alu_C_i(alu_c),
        .br_i(br), .jal_i(jal), .jalr_i(jalr), .brty_i(brty),
        .imme_i(imme), .rs1_i(rs1),
        .redirect_valid_o(rv), .redirect_pc_o(rpc),
        .redirect_ready_i(redirect_ready),
        .pc_o(pc_out), .link_valid_o(lv), .link_o(lnk),
        .exc_valid_o(ev), .exc_cause_o(cause), .exc_tval_o(tval),
        .trap_clear_i(trap_clear), .trap_vec_i(trap_vec),
        .retire_cnt_o(rcnt), .taken_cnt_o(tcnt)
    );

    next_pc_unit #(.IALIGN(16)) dut16 (
        .clk(clk), .rst_n(rst16_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready16),
        .pc_i(pc_in), .alu_C_i(alu_c),
        .br_i(br), .jal_i(jal), .jalr_i(jalr), .brty_i(brty),
        .imme_i(imme), .rs1_i(rs1),
        .redirect_valid_o(rv16), .redirect_pc_o(rpc16),
        .redirect_ready_i(redirect_ready),
        .pc_o(pc16), .link_valid_o(lv16), .link_o(lnk16),
        .exc_valid_o(ev16), .exc_cause_o(cause16), .exc_tval_o(tval16),
        .trap_clear_i(trap_clear), .trap_vec_i(trap_vec),
        .retire_cnt_o(rcnt16), .taken_cnt_o(tcnt16)
    );

    function automatic obs_t sample_main();
        return '{rdy: in_ready, rv: rv, rpc: rpc, pc: pc_out, lv: lv,
            lnk: lnk, ev: ev, cause: cause, tval: tval,
            rcnt: rcnt, tcnt: tcnt};
    endfunction

    function automatic obs_t sample16();
        return '{rdy: in_ready16, rv: rv16, rpc: rpc16, pc: pc16, lv: lv16,
            lnk: lnk16, ev: ev16, cause: cause16, tval: tval16,
            rcnt: rcnt16, tcnt: tcnt16};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; br = 1'b0; jal = 1'b0; jalr = 1'b0;
        brty = 3'b000; alu_c = '0; imme = '0; rs1 = '0; pc_in = '0;
        trap_clear = 1'b0; trap_vec = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst16_n = 1'b0;
        redirect_ready = 1'b0;
        idle_inputs();
        tick();
        got = sample_main();
        n_checks++;
        if (got !== RST_OBS) begin
            n_fail++;
            $display("FAIL reset: got %h want %h", got, RST_OBS);
        end
        rst_n = 1'b1;
        e = RST_OBS;
    endtask

    task automatic test_beq_hold();
        in_valid = 1'b1; pc_in = 64'h100; br = 1'b1; brty = 3'b000;
        alu_c = 64'h0; imme = 64'h20; redirect_ready = 1'b0;
        e.rdy = 1'b0; e.rv = 1'b1; e.rpc = 64'h120; e.pc = 64'h120;
        e.rcnt++; e.tcnt++;
        exp_q.push_back(e);
        tick();
        pc_in = 64'h900;
        for (int i = 0; i < 3; i++) begin
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL beq_hold[%0d]: got %h want %h", i, got, want);
            end
            if (i < 2) begin
                exp_q.push_back(e);
                tick();
            end
        end
        in_valid = 1'b0; redirect_ready = 1'b1;
        e.rv = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL beq_release: got %h want %h", got, want);
        end
        redirect_ready = 1'b0; br = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; br = 1'b1; brty = 3'b001; alu_c = 64'h0;
            imme = 64'h40; pc_in = 64'h200 + 64'(4 * k);
            e.pc = 64'h204 + 64'(4 * k);
            e.rcnt++;
            exp_q.push_back(e);
            tick();
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got %h want %h", k, got, want);
            end
        end
        in_valid = 1'b0; br = 1'b0;
    endtask

    task automatic test_brtypes();
        logic [2:0]  tys[8];
        logic [63:0] alus[8];
        logic        tks[8];
        tys  = '{3'b000, 3'b000, 3'b001, 3'b100,
                 3'b100, 3'b101, 3'b110, 3'b111};
        alus = '{64'd0, 64'd5, 64'd5, 64'd1, 64'd0, 64'd0, 64'd1, 64'd1};
        tks  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        redirect_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; br = 1'b1; brty = tys[i]; alu_c = alus[i];
            imme = 64'h80; pc_in = 64'h1000 + 64'(16 * i);
            e.rcnt++;
            if (tks[i]) begin
                e.pc = pc_in + 64'h80; e.rv = 1'b1; e.rpc = e.pc;
                e.rdy = 1'b0; e.tcnt++;
            end else begin
                e.pc = pc_in + 64'h4;
            end
            exp_q.push_back(e);
            tick();
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL brty[%0d]: got %h want %h", i, got, want);
            end
            if (tks[i]) begin
                in_valid = 1'b0;
                e.rv = 1'b0; e.rdy = 1'b1;
                exp_q.push_back(e);
                tick();
                got = sample_main(); want = exp_q.pop_front(); n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL brty_rel[%0d]: got %h want %h", i, got, want);
                end
            end
        end
        in_valid = 1'b0; br = 1'b0; redirect_ready = 1'b0;
    endtask

    task automatic test_jalr_link();
        in_valid = 1'b1; jalr = 1'b1; pc_in = 64'h40;
        rs1 = 64'h2001; imme = 64'h4;
        e.rdy = 1'b0; e.rv = 1'b1; e.rpc = 64'h2004; e.pc = 64'h2004;
        e.lv = 1'b1; e.lnk = 64'h44; e.rcnt++; e.tcnt++;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL jalr: got %h want %h", got, want);
        end
        in_valid = 1'b0; jalr = 1'b0; redirect_ready = 1'b1;
        e.lv = 1'b0; e.rv = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL jalr_pulse: got %h want %h", got, want);
        end
        redirect_ready = 1'b0;
    endtask

    task automatic test_misalign();
        rst16_n = 1'b1;
        in_valid = 1'b1; jal = 1'b1; pc_in = 64'h100; imme = 64'h6;
        e.rdy = 1'b0; e.ev = 1'b1; e.cause = 2'd0; e.tval = 64'h106;
        e16 = RST_OBS;
        e16.rdy = 1'b0; e16.rv = 1'b1; e16.rpc = 64'h106; e16.pc = 64'h106;
        e16.lv = 1'b1; e16.lnk = 64'h104; e16.rcnt = 32'd1; e16.tcnt = 32'd1;
        exp_q.push_back(e);
        exp_q.push_back(e16);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL misalign32: got %h want %h", got, want);
        end
        got = sample16(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL align16: got %h want %h", got, want);
        end
        jal = 1'b0; pc_in = 64'h700;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL trap_sticky: got %h want %h", got, want);
        end
        in_valid = 1'b0; trap_clear = 1'b1; trap_vec = 64'h1000;
        e.ev = 1'b0; e.pc = 64'h1000; e.rv = 1'b1; e.rpc = 64'h1000;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL trap_clear0: got %h want %h", got, want);
        end
        trap_clear = 1'b0; redirect_ready = 1'b1;
        e.rv = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL trap_exit0: got %h want %h", got, want);
        end
        redirect_ready = 1'b0;
        rst16_n = 1'b0;
    endtask

    task automatic test_illegal();
        logic [2:0] bad[2];
        bad = '{3'b010, 3'b011};
        trap_clear = 1'b1; trap_vec = 64'h999;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL clear_in_run: got %h want %h", got, want);
        end
        trap_clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; br = 1'b1; brty = bad[i]; alu_c = 64'h0;
            imme = 64'h21; pc_in = 64'h300 + 64'(4 * i);
            e.rdy = 1'b0; e.ev = 1'b1; e.cause = 2'd2; e.tval = pc_in;
            exp_q.push_back(e);
            tick();
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL illegal[%0d]: got %h want %h", i, got, want);
            end
            in_valid = 1'b0; br = 1'b0;
            trap_clear = 1'b1; trap_vec = 64'h800 + 64'(2 * i);
            e.ev = 1'b0; e.pc = trap_vec; e.rv = 1'b1; e.rpc = trap_vec;
            exp_q.push_back(e);
            tick();
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL trap_vec[%0d]: got %h want %h", i, got, want);
            end
            trap_clear = 1'b0; redirect_ready = 1'b1;
            e.rv = 1'b0; e.rdy = 1'b1;
            exp_q.push_back(e);
            tick();
            got = sample_main(); want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL trap_exit[%0d]: got %h want %h", i, got, want);
            end
            redirect_ready = 1'b0;
        end
    endtask

    task automatic test_async_reset_wrap();
        in_valid = 1'b1; jal = 1'b1; pc_in = 64'h500; imme = 64'h100;
        e.rdy = 1'b0; e.rv = 1'b1; e.rpc = 64'h600; e.pc = 64'h600;
        e.lv = 1'b1; e.lnk = 64'h504; e.rcnt++; e.tcnt++;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL hold_pre_rst: got %h want %h", got, want);
        end
        in_valid = 1'b0; jal = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        e = RST_OBS;
        exp_q.push_back(e);
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_rst: got %h want %h", got, want);
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; jal = 1'b1; pc_in = '1; imme = 64'h4;
        e.rdy = 1'b0; e.ev = 1'b1; e.cause = 2'd0; e.tval = 64'h3;
        exp_q.push_back(e);
        tick();
        got = sample_main(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL wrap_trap: got %h want %h", got, want);
        end
        in_valid = 1'b0; jal = 1'b0;
    endtask

    initial begin
        test_reset();
        test_beq_hold();
        test_back_to_back();
        test_brtypes();
        test_jalr_link();
        test_misalign();
        test_illegal();
        test_async_reset_wrap();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
